// File: rtl/pb_conditioner.sv
// Two-channel pushbutton conditioner: 2-flop sync, debounce FSM, one-cycle press pulse, cross-channel lockout.
// Optional auto-repeat while held is compiled in with `define PB_AUTOREPEAT_EN.
module pb_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic CLK_50,
  input  logic reset,
  input  logic key_up_n,
  input  logic key_dn_n,
  output logic pb_freq_up,
  output logic pb_freq_dn,
  output logic up_held,
  output logic dn_held
);

  // state     | meaning
  // IDLE      | released, waiting for a pressed sample
  // PRESS_CHK | counting consecutive pressed samples
  // HELD      | debounced pressed
  // REL_CHK   | counting consecutive released samples
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if ((DEBOUNCE_CYCLES < 1) || ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES))) begin : g_bad_cnt_w
    $error("pb_conditioner: CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if ((REPEAT_PERIOD < 1) || (REPEAT_PERIOD > REPEAT_DELAY)) begin : g_bad_repeat
    $error("pb_conditioner: REPEAT_PERIOD must be in 1..REPEAT_DELAY");
  end

  // Channel 0 = up, channel 1 = down.
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       key_act;
  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       enter_held;
  logic [1:0]       rpt_fire;
  logic [1:0]       held_q, held_d;
  logic [1:0]       pulse_q, pulse_d;

  assign key_act = ~sync2_q;

  always_comb begin
    enter_held = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (key_act[i]) state_d[i] = PRESS_CHK;
        end
        PRESS_CHK: begin
          if (!key_act[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]    = HELD;
            cnt_d[i]      = '0;
            enter_held[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        HELD: begin
          cnt_d[i] = '0;
          if (!key_act[i]) state_d[i] = REL_CHK;
        end
        REL_CHK: begin
          if (key_act[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

`ifdef PB_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_q [2];
  logic [RPT_W-1:0] rpt_d [2];

  // Only counts while staying in HELD; reloading to DELAY-PERIOD gives the periodic cadence.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < 2; i++) begin
      rpt_d[i] = '0;
      if ((state_q[i] == HELD) && (state_d[i] == HELD)) begin
        if (rpt_q[i] == RPT_LAST) begin
          rpt_fire[i] = 1'b1;
          rpt_d[i]    = RPT_RELOAD;
        end else begin
          rpt_d[i] = rpt_q[i] + RPT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK_50) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) rpt_q[i] <= '0;
      else       rpt_q[i] <= rpt_d[i];
    end
  end
`else
  assign rpt_fire = '0;
`endif

  // A channel may not pulse while the other is held or is becoming held this same cycle.
  always_comb begin
    held_d  = '0;
    pulse_d = '0;
    for (int i = 0; i < 2; i++) begin
      held_d[i]  = (state_d[i] == HELD) || (state_d[i] == REL_CHK);
      pulse_d[i] = (enter_held[i] | rpt_fire[i]) & ~(held_q[1-i] | enter_held[1-i]);
    end
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      held_q  <= '0;
      pulse_q <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= {key_dn_n, key_up_n};
      sync2_q <= sync1_q;
      held_q  <= held_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign pb_freq_up = pulse_q[0];
  assign pb_freq_dn = pulse_q[1];
  assign up_held    = held_q[0];
  assign dn_held    = held_q[1];

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: directed scenarios plus random key activity against a run-length reference model.
module tb_pb_conditioner;
  localparam int D  = 8;
  localparam int RD = 40;
  localparam int RP = 10;

  logic CLK_50   = 1'b0;
  logic reset    = 1'b1;
  logic key_up_n = 1'b1;
  logic key_dn_n = 1'b1;
  logic pb_freq_up, pb_freq_dn, up_held, dn_held;
  int   n_cmp = 0;
  int   n_bad = 0;

  pb_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(4),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .CLK_50(CLK_50),
    .reset(reset),
    .key_up_n(key_up_n),
    .key_dn_n(key_dn_n),
    .pb_freq_up(pb_freq_up),
    .pb_freq_dn(pb_freq_dn),
    .up_held(up_held),
    .dn_held(dn_held)
  );

  always #10 CLK_50 = ~CLK_50;

  // Reference model: two-sample input delay, then a level changes after D+1 consecutive
  // opposite samples; hold age counts uninterrupted pressed samples since acceptance.
  logic [1:0] m_pipe1 = 2'b11, m_pipe2 = 2'b11;
  logic [1:0] m_level = 2'b00, m_held = 2'b00, m_pulse = 2'b00;
  int m_run [2] = '{0, 0};
  int m_age [2] = '{0, 0};

  always @(posedge CLK_50) begin
    logic [1:0] s, acc, rep;
    if (reset) begin
      m_pipe1 = 2'b11; m_pipe2 = 2'b11;
      m_level = 2'b00; m_held = 2'b00; m_pulse = 2'b00;
      m_run = '{0, 0}; m_age = '{0, 0};
    end else begin
      s = ~m_pipe2;
      m_pipe2 = m_pipe1;
      m_pipe1 = {key_dn_n, key_up_n};
      acc = 2'b00;
      rep = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (!m_level[i]) begin
          m_run[i] = s[i] ? m_run[i] + 1 : 0;
          if (m_run[i] == D + 1) begin
            m_level[i] = 1'b1; m_run[i] = 0; m_age[i] = 0; acc[i] = 1'b1;
          end
        end else if (!s[i]) begin
          m_run[i] = m_run[i] + 1;
          m_age[i] = 0;
          if (m_run[i] == D + 1) begin
            m_level[i] = 1'b0; m_run[i] = 0;
          end
        end else if (m_run[i] != 0) begin
          m_run[i] = 0;
          m_age[i] = 0;
        end else begin
          m_age[i] = m_age[i] + 1;
`ifdef PB_AUTOREPEAT_EN
          rep[i] = (m_age[i] >= RD) && (((m_age[i] - RD) % RP) == 0);
`endif
        end
      end
      for (int i = 0; i < 2; i++)
        m_pulse[i] = (acc[i] | rep[i]) & ~(m_held[1-i] | acc[1-i]);
      m_held = m_level;
    end
  end

  logic [3:0] dut_v, exp_v;
  assign dut_v = {pb_freq_up, pb_freq_dn, up_held, dn_held};
  assign exp_v = {m_pulse[0], m_pulse[1], m_held[0], m_held[1]};

  task automatic step(input logic up_n, input logic dn_n);
    key_up_n = up_n;
    key_dn_n = dn_n;
    @(negedge CLK_50);
  endtask

  task automatic test_reset();
    int first, cnt;
    reset = 1'b1;
    key_up_n = 1'b0;
    key_dn_n = 1'b1;
    repeat (4) @(negedge CLK_50);
    n_cmp++;
    if (dut_v !== 4'b0000) begin
      n_bad++; $display("FAIL reset_state: got %b want 0000", dut_v);
    end
    reset = 1'b0;
    first = -1; cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b1);
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL reset_hold cyc %0d: got %b model %b", k, dut_v, exp_v);
      end
      if (pb_freq_up) begin cnt++; if (first < 0) first = k; end
    end
    n_cmp++;
    if (cnt !== 1 || first !== D + 2) begin
      n_bad++; $display("FAIL reset_pulse: got count %0d at %0d want 1 at %0d", cnt, first, D + 2);
    end
    n_cmp++;
    if (up_held !== 1'b1) begin
      n_bad++; $display("FAIL reset_held: got %b want 1", up_held);
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1);
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL reset_release cyc %0d: got %b model %b", k, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_clean_press();
    int first, cnt, fall;
    first = -1; cnt = 0; fall = -1;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 1'b1);
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL clean_press cyc %0d: got %b model %b", k, dut_v, exp_v);
      end
      if (pb_freq_up) begin cnt++; if (first < 0) first = k; end
    end
    n_cmp++;
    if (cnt !== 1 || first !== D + 2) begin
      n_bad++; $display("FAIL clean_pulse: got count %0d at %0d want 1 at %0d", cnt, first, D + 2);
    end
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1);
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL clean_release cyc %0d: got %b model %b", k, dut_v, exp_v);
      end
      if (pb_freq_up) cnt++;
      if (!up_held && fall < 0) fall = k;
    end
    n_cmp++;
    if (fall !== D + 2 || cnt !== 0) begin
      n_bad++; $display("FAIL clean_release_timing: held fell at %0d with %0d pulses, want %0d with 0", fall, cnt, D + 2);
    end
  endtask

  task automatic test_bounce();
    int t, first, cnt;
    t = 0; first = -1; cnt = 0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) begin
        step(1'b1, (k < 5) ? 1'b0 : 1'b1);
        n_cmp++;
        if (dut_v !== exp_v) begin
          n_bad++; $display("FAIL bounce cyc %0d: got %b model %b", t, dut_v, exp_v);
        end
        if (pb_freq_dn) begin cnt++; if (first < 0) first = t; end
        t++;
      end
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL bounce_hold cyc %0d: got %b model %b", t, dut_v, exp_v);
      end
      if (pb_freq_dn) begin cnt++; if (first < 0) first = t; end
      t++;
    end
    n_cmp++;
    if (cnt !== 1 || first !== 32 + D + 2) begin
      n_bad++; $display("FAIL bounce_pulse: got count %0d at %0d want 1 at %0d", cnt, first, 32 + D + 2);
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1);
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL bounce_release cyc %0d: got %b model %b", k, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    int seen;
    seen = 0;
    for (int k = 0; k < 27; k++) begin
      step((k < 7) ? 1'b0 : 1'b1, 1'b1);
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL glitch cyc %0d: got %b model %b", k, dut_v, exp_v);
      end
      if (pb_freq_up || up_held) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL glitch_quiet: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_lockout();
    int dn_p, up_p;
    dn_p = 0; up_p = 0;
    for (int k = 0; k < 60; k++) begin
      step(1'b0, (k < 30) ? 1'b1 : 1'b0);
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL lockout_seq cyc %0d: got %b model %b", k, dut_v, exp_v);
      end
      if (pb_freq_dn) dn_p++;
    end
    n_cmp++;
    if (dn_p !== 0 || dn_held !== 1'b1) begin
      n_bad++; $display("FAIL lockout_seq_result: dn pulses %0d dn_held %b want 0 and 1", dn_p, dn_held);
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1);
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL lockout_rel1 cyc %0d: got %b model %b", k, dut_v, exp_v);
      end
    end
    dn_p = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 1'b0);
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL lockout_same cyc %0d: got %b model %b", k, dut_v, exp_v);
      end
      if (pb_freq_dn) dn_p++;
      if (pb_freq_up) up_p++;
    end
    n_cmp++;
    if (dn_p !== 0 || up_p !== 0 || up_held !== 1'b1 || dn_held !== 1'b1) begin
      n_bad++; $display("FAIL lockout_same_result: pulses up %0d dn %0d held %b%b want 0 0 11", up_p, dn_p, up_held, dn_held);
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1);
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL lockout_rel2 cyc %0d: got %b model %b", k, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_long_hold();
    int got_q[$];
    int exp_q[$];
`ifdef PB_AUTOREPEAT_EN
    exp_q = {10, 50, 60, 70, 80, 90, 100};
`else
    exp_q = {10};
`endif
    for (int k = 0; k < 120; k++) begin
      step((k < 100) ? 1'b0 : 1'b1, 1'b1);
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL long_hold cyc %0d: got %b model %b", k, dut_v, exp_v);
      end
      if (pb_freq_up) got_q.push_back(k);
    end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL long_hold_count: got %0d pulses want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        n_cmp++;
        if (got_q[j] !== exp_q[j]) begin
          n_bad++; $display("FAIL long_hold_pulse %0d: got cycle %0d want %0d", j, got_q[j], exp_q[j]);
        end
      end
    end
  endtask

  task automatic test_random();
    int rem_up, rem_dn, pulses;
    logic up_n, dn_n;
    up_n = 1'b1; dn_n = 1'b1;
    rem_up = $urandom_range(1, 24);
    rem_dn = $urandom_range(1, 24);
    pulses = 0;
    for (int k = 0; k < 3000; k++) begin
      if (--rem_up == 0) begin up_n = ~up_n; rem_up = $urandom_range(1, 24); end
      if (--rem_dn == 0) begin dn_n = ~dn_n; rem_dn = $urandom_range(1, 24); end
      reset = ($urandom_range(0, 399) == 0);
      step(up_n, dn_n);
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL random cyc %0d: got %b model %b", k, dut_v, exp_v);
      end
      n_cmp++;
      if (pb_freq_up && pb_freq_dn) begin
        n_bad++; $display("FAIL random_exclusive cyc %0d: got both pulses want at most one", k);
      end
      if (pb_freq_up || pb_freq_dn) pulses++;
    end
    reset = 1'b0;
    n_cmp++;
    if (pulses < 1) begin
      n_bad++; $display("FAIL random_activity: got %0d pulses want at least 1", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_lockout();
    test_long_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
